// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: two producer FIFOs share the register file's single write port.
// Optional round-robin arbitration via `define WBARB_ROUND_ROBIN_EN (default: fixed priority, B wins).
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          wb_en,
  output logic          idle
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid && ready; ready depends
  // only on the registered count, never on valid, so a full FIFO never passes data through.

  // ---------------- source A FIFO ----------------
  logic [AW+DW-1:0] r_a_mem [DEPTH];
  logic [PW-1:0]    r_a_wptr;
  logic [PW-1:0]    r_a_rptr;
  logic [CW-1:0]    r_a_cnt;
  logic             w_a_push;
  logic             w_a_pop;
  logic             w_a_ne;
  logic [AW+DW-1:0] w_a_head;

  assign a_ready  = (r_a_cnt != FULL);
  // Writes to register 0 complete the handshake but are dropped here.
  assign w_a_push = a_valid && a_ready && (a_reg != '0);
  assign w_a_ne   = (r_a_cnt != '0);
  assign w_a_head = r_a_mem[r_a_rptr];

  always_ff @(posedge clk) begin
    if (w_a_push) r_a_mem[r_a_wptr] <= {a_reg, a_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_wptr <= '0;
      r_a_rptr <= '0;
      r_a_cnt  <= '0;
    end else begin
      if (w_a_push) r_a_wptr <= r_a_wptr + 1'b1;
      if (w_a_pop)  r_a_rptr <= r_a_rptr + 1'b1;
      case ({w_a_push, w_a_pop})
        2'b10:   r_a_cnt <= r_a_cnt + CW'(1);
        2'b01:   r_a_cnt <= r_a_cnt - CW'(1);
        default: r_a_cnt <= r_a_cnt;
      endcase
    end
  end

  // ---------------- source B FIFO ----------------
  logic [AW+DW-1:0] r_b_mem [DEPTH];
  logic [PW-1:0]    r_b_wptr;
  logic [PW-1:0]    r_b_rptr;
  logic [CW-1:0]    r_b_cnt;
  logic             w_b_push;
  logic             w_b_pop;
  logic             w_b_ne;
  logic [AW+DW-1:0] w_b_head;

  assign b_ready  = (r_b_cnt != FULL);
  assign w_b_push = b_valid && b_ready && (b_reg != '0);
  assign w_b_ne   = (r_b_cnt != '0);
  assign w_b_head = r_b_mem[r_b_rptr];

  always_ff @(posedge clk) begin
    if (w_b_push) r_b_mem[r_b_wptr] <= {b_reg, b_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_wptr <= '0;
      r_b_rptr <= '0;
      r_b_cnt  <= '0;
    end else begin
      if (w_b_push) r_b_wptr <= r_b_wptr + 1'b1;
      if (w_b_pop)  r_b_rptr <= r_b_rptr + 1'b1;
      case ({w_b_push, w_b_pop})
        2'b10:   r_b_cnt <= r_b_cnt + CW'(1);
        2'b01:   r_b_cnt <= r_b_cnt - CW'(1);
        default: r_b_cnt <= r_b_cnt;
      endcase
    end
  end

  // ---------------- grant ----------------
  logic w_gnt_a;
  logic w_gnt_b;

`ifdef WBARB_ROUND_ROBIN_EN
  // r_rr_b set means B is favoured on the next contended cycle.
  logic r_rr_b;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_a_ne && w_b_ne) begin
      w_gnt_a = !r_rr_b;
      w_gnt_b = r_rr_b;
    end else begin
      w_gnt_a = w_a_ne;
      w_gnt_b = w_b_ne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_b <= 1'b0;
    end else if (w_gnt_a) begin
      r_rr_b <= 1'b1;
    end else if (w_gnt_b) begin
      r_rr_b <= 1'b0;
    end
  end
`else
  // Load results (B) always win; A waits while B has anything queued.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (w_b_ne) begin
      w_gnt_b = 1'b1;
    end else begin
      w_gnt_a = w_a_ne;
    end
  end
`endif

  assign w_a_pop = w_gnt_a;
  assign w_b_pop = w_gnt_b;

  // ---------------- registered write port ----------------
  logic [AW-1:0] r_wb_reg;
  logic [DW-1:0] r_wb_data;
  logic          r_wb_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_reg  <= '0;
      r_wb_data <= '0;
      r_wb_en   <= 1'b0;
    end else begin
      r_wb_en <= w_gnt_a || w_gnt_b;
      if (w_gnt_b) begin
        {r_wb_reg, r_wb_data} <= w_b_head;
      end else if (w_gnt_a) begin
        {r_wb_reg, r_wb_data} <= w_a_head;
      end
    end
  end

  assign wb_reg  = r_wb_reg;
  assign wb_data = r_wb_data;
  assign wb_en   = r_wb_en;
  assign idle    = !w_a_ne && !w_b_ne && !r_wb_en;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, reg-0 filter, contention, backpressure,
// wrap-around streaming and asynchronous reset mid-operation.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk;
  logic          rst_n;
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic [AW-1:0] wb_reg;
  logic [DW-1:0] wb_data;
  logic          wb_en;
  logic          idle;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW+DW-1:0] exp_q[$];

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_reg   (a_reg),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_reg   (b_reg),
    .b_data  (b_data),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .wb_en   (wb_en),
    .idle    (idle)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    a_valid = v;
    a_reg   = r;
    a_data  = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    b_valid = v;
    b_reg   = r;
    b_data  = d;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag, input logic [AW-1:0] r, input logic [DW-1:0] d);
    check({tag, "_en"}, 64'(wb_en), 64'd1);
    check({tag, "_reg"}, 64'(wb_reg), 64'(r));
    check({tag, "_data"}, 64'(wb_data), 64'(d));
  endtask

  // scoreboard: compare one expected write against the port
  task automatic sb_expect(input string tag);
    logic [AW+DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s observed=write expected=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      check_wb(tag, e[AW+DW-1:DW], e[DW-1:0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    #3;
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_wb_reg", 64'(wb_reg), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_a_ready", 64'(a_ready), 64'd1);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single write from A
    drive_a(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive_a(1'b0, '0, '0);
    check("single_acc_wb_en", 64'(wb_en), 64'd0);
    check("single_acc_idle", 64'(idle), 64'd0);
    tick();
    check_wb("single_wb", 5'd5, 32'hDEADBEEF);
    tick();
    check("single_after_en", 64'(wb_en), 64'd0);
    check("single_after_idle", 64'(idle), 64'd1);
    check("single_hold_reg", 64'(wb_reg), 64'd5);

    // register 0 discard
    drive_a(1'b1, 5'd0, 32'h1234);
    check("reg0_ready", 64'(a_ready), 64'd1);
    tick();
    drive_a(1'b0, '0, '0);
    check("reg0_idle", 64'(idle), 64'd1);
    tick();
    check("reg0_wb_en", 64'(wb_en), 64'd0);
    check("reg0_idle2", 64'(idle), 64'd1);

    // contention: A gets regs 1,2 and B regs 3,4
    drive_a(1'b1, 5'd1, 32'hA1);
    drive_b(1'b1, 5'd3, 32'hB3);
    tick();
    drive_a(1'b1, 5'd2, 32'hA2);
    drive_b(1'b1, 5'd4, 32'hB4);
    tick();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
`ifdef WBARB_ROUND_ROBIN_EN
    check_wb("rr_0", 5'd1, 32'hA1);
    tick();
    check_wb("rr_1", 5'd3, 32'hB3);
    tick();
    check_wb("rr_2", 5'd2, 32'hA2);
    tick();
    check_wb("rr_3", 5'd4, 32'hB4);
`else
    check_wb("fp_0", 5'd3, 32'hB3);
    tick();
    check_wb("fp_1", 5'd4, 32'hB4);
    tick();
    check_wb("fp_2", 5'd1, 32'hA1);
    tick();
    check_wb("fp_3", 5'd2, 32'hA2);
`endif
    tick();
    check("cont_end_en", 64'(wb_en), 64'd0);
    check("cont_end_idle", 64'(idle), 64'd1);

`ifndef WBARB_ROUND_ROBIN_EN
    // backpressure: B keeps the port busy, A fills up
    drive_a(1'b1, 5'd20, 32'hA000);
    drive_b(1'b1, 5'd10, 32'hB000);
    tick();
    check("bp_ready_1", 64'(a_ready), 64'd1);
    check("bp_en_1", 64'(wb_en), 64'd0);
    drive_a(1'b1, 5'd21, 32'hA001);
    drive_b(1'b1, 5'd11, 32'hB001);
    tick();
    check("bp_ready_full", 64'(a_ready), 64'd0);
    check_wb("bp_b0", 5'd10, 32'hB000);
    drive_a(1'b1, 5'd22, 32'hA002);
    drive_b(1'b1, 5'd12, 32'hB002);
    tick();
    check("bp_ready_hold1", 64'(a_ready), 64'd0);
    check_wb("bp_b1", 5'd11, 32'hB001);
    drive_b(1'b1, 5'd13, 32'hB003);
    tick();
    check("bp_ready_hold2", 64'(a_ready), 64'd0);
    check_wb("bp_b2", 5'd12, 32'hB002);
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    tick();
    check("bp_ready_hold3", 64'(a_ready), 64'd0);
    check_wb("bp_b3", 5'd13, 32'hB003);
    tick();
    check("bp_ready_rise", 64'(a_ready), 64'd1);
    check_wb("bp_a0", 5'd20, 32'hA000);
    tick();
    check_wb("bp_a1", 5'd21, 32'hA001);
    tick();
    check("bp_end_en", 64'(wb_en), 64'd0);
    check("bp_end_idle", 64'(idle), 64'd1);
`endif

    // wrap-around stream through A at full rate
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      logic [AW-1:0] r;
      r = AW'(i % 31 + 1);
      drive_a(1'b1, r, 32'(i));
      exp_q.push_back({r, 32'(i)});
      check("wrap_ready", 64'(a_ready), 64'd1);
      tick();
      if (i > 0) sb_expect("wrap");
    end
    drive_a(1'b0, '0, '0);
    tick();
    sb_expect("wrap_last");
    check("wrap_q_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("wrap_end_en", 64'(wb_en), 64'd0);

    // reset mid-operation
    drive_a(1'b1, 5'd7, 32'h77);
    drive_b(1'b1, 5'd8, 32'h88);
    tick();
    drive_a(1'b1, 5'd9, 32'h99);
    drive_b(1'b1, 5'd6, 32'h66);
    tick();
    drive_a(1'b0, '0, '0);
    drive_b(1'b0, '0, '0);
    check("mid_pre_en", 64'(wb_en), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", 64'(wb_en), 64'd0);
    check("mid_rst_reg", 64'(wb_reg), 64'd0);
    check("mid_rst_data", 64'(wb_data), 64'd0);
    check("mid_rst_idle", 64'(idle), 64'd1);
    check("mid_rst_a_ready", 64'(a_ready), 64'd1);
    check("mid_rst_b_ready", 64'(b_ready), 64'd1);
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_stale_en", 64'(wb_en), 64'd0);
      check("mid_no_stale_idle", 64'(idle), 64'd1);
    end
    drive_a(1'b1, 5'd3, 32'h55);
    tick();
    drive_a(1'b0, '0, '0);
    tick();
    check_wb("mid_fresh", 5'd3, 32'h55);
    tick();
    check("mid_fresh_end", 64'(wb_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter that shares the register file's single write port between two producers: source A (ALU results) and source B (load/memory results). Each source pushes (register, data) pairs through a valid/ready handshake into a private FIFO. The arbiter drains one entry per cycle into a registered write port that drives the register file's write_reg, data_in and ranwi inputs directly. It sits between the execute/memory stages and the 32x32 register file.

## Interface

Parameters:
- DEPTH, 2: entries per source FIFO; power of two, 2..8.
- AW, 5: register address width.
- DW, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  source A presents a write.
- a_ready  out  1  source A FIFO can accept.
- a_reg  in  AW  source A destination register.
- a_data  in  DW  source A data.
- b_valid, b_ready, b_reg, b_data: same as the A ports, for source B.
- wb_reg  out  AW  write address to the register file (write_reg).
- wb_data  out  DW  write data to the register file (data_in).
- wb_en  out  1  write enable to the register file (ranwi).
- idle  out  1  both FIFOs are empty and wb_en is low.

## Operation

- **Accept.** A source transfer occurs on a rising edge where valid && ready.
  - x_ready = (count_x != DEPTH), derived from registered count only; no pass-through when full.
- **Register 0 filter.** A transfer with x_reg == 0 completes the handshake and is discarded. It is not enqueued and never reaches wb_en.
- **FIFO.** Each source has a circular buffer with wrap-around read/write pointers and a count.
  - Push and pop in the same cycle leave count unchanged.
  - Order within one source is preserved. No ordering is guaranteed between A and B.
- **Grant.** Each cycle, at most one FIFO head is selected:
  - Only one source non-empty: grant that source.
  - Both non-empty: decided by the arbitration policy (see Configuration).
  - Neither non-empty: no grant.
- **Write-port register.** On a grant, the selected head is popped and loaded into wb_reg/wb_data, and wb_en is set to 1. With no grant, wb_en is set to 0 and wb_reg/wb_data hold their previous values.
- **Reset (asynchronous, any time).**
  - FIFOs emptied; pointers and counts set to 0.
  - wb_en=0, wb_reg=0, wb_data=0.
  - Round-robin pointer favours A.
  - a_ready = b_ready = 1 and idle = 1 as soon as rst_n is low.
  - Entries in flight are lost.
  - Sources must hold valid low while rst_n is low.

## Timing

- **Latency.** A transfer accepted at edge k into an empty FIFO, with no contention:
  - can be granted at edge k+1, so wb_en is high during cycle k+1..k+2;
  - is committed to the register file at edge k+2.
- **Throughput.** One register-file write per cycle in aggregate. A single source alone sustains 1 write/cycle.
- **Ready.** x_ready falls in the cycle after the edge that fills the FIFO. It rises in the cycle after the edge that pops the FIFO from full.
- **Contention.** Under sustained contention, round-robin grants alternate A,B,A,B.
- **idle.** idle is combinational from registered state. It is high exactly when count_a == 0, count_b == 0 and wb_en == 0.

## Configuration

- Macro WBARB_ROUND_ROBIN_EN.
- **Defined:** round-robin arbitration. When both FIFOs are non-empty, grant the source named by the pointer. After any grant, the pointer is set to the other source. Single-source grants also update the pointer.
- **Undefined:** fixed priority. When both are non-empty, B (load results) always wins. A waits, and a_ready stays low while A's FIFO is full. No pointer flop exists.

## Test plan

- **Reset release, single write.** Reset, then A sends (reg=5, data=0xDEADBEEF) at edge 1 → wb_en=1, wb_reg=5, wb_data=0xDEADBEEF in cycle 2..3 only; idle=1 afterwards.
- **Register 0 discard.** A sends reg=0, data=0x1234 → handshake completes, wb_en never asserts, count_a stays 0.
- **Contention.** Preload A with regs 1,2 and B with regs 3,4, then stop inputs.
  - Round robin: wb_reg sequence 1,3,2,4 (pointer reset favours A).
  - Fixed priority: 3,4,1,2.
- **Backpressure.** With B held busy in fixed-priority mode, push DEPTH entries to A → a_ready=0 the cycle after the DEPTH-th accept. a_valid held high does not enqueue. After B drains, A's entries emerge in order with no loss or duplication.
- **Wrap-around.** Stream 3*DEPTH+1 sequential writes (reg=i%31+1, data=i) through A alone at full rate → the wb sequence matches exactly at 1 write/cycle once the pipeline fills.
- **Reset mid-operation.** With both FIFOs partially full and wb_en=1, pulse rst_n low mid-cycle:
  - Immediately: wb_en=0, wb_reg=0, wb_data=0, idle=1, ready=1.
  - After reset: no stale entries are ever written.
